// File: rtl/axis_pkt_sched_pkg.sv
// Shared types and constants for the two-source AXI-Stream packet scheduler.
package axis_pkt_sched_pkg;

    localparam int unsigned NUM_SRC = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

    typedef logic [$clog2(NUM_SRC)-1:0] src_idx_t;

    // Round-robin partner of a source index.
    function automatic src_idx_t other_src(input src_idx_t idx);
        return idx ^ src_idx_t'(1);
    endfunction

endpackage

// File: rtl/pkt_beat_counter.sv
// Beat counter for the packet in flight; flags the final beat of the packet.
module pkt_beat_counter
    import axis_pkt_sched_pkg::*;
#(
    parameter int unsigned CNTR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [CNTR_WIDTH-1:0] length,
    output logic                  terminal
);

    logic [CNTR_WIDTH-1:0] count;

    // Count accepted beats; cleared on reset and at every new grant.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNTR_WIDTH'(1);
        end
    end

    assign terminal = (count == length);

endmodule

// File: rtl/axis_packet_scheduler.sv
// Round-robin packetizer: grants one of two AXI-Stream sources for a packet of
// cfg_data+1 beats and passes its data straight through to the master port.
module axis_packet_scheduler
    import axis_pkt_sched_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    input  logic                        cfg_enable,
    input  logic [AXIS_TDATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                        s0_axis_tvalid,
    output logic                        s0_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                        s1_axis_tvalid,
    output logic                        s1_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tid,
    output logic [31:0]                 sts_packets
);

    sched_state_t          state_q, state_d;
    src_idx_t              rr_ptr;
    src_idx_t              tid_q;
    src_idx_t              grant_idx;
    logic                  grant;
    logic                  handshake;
    logic                  terminal;
    logic [CNTR_WIDTH-1:0] len_q;
    logic [31:0]           sts_q;
    logic [NUM_SRC-1:0]    src_tvalid;

    assign src_tvalid = {s1_axis_tvalid, s0_axis_tvalid};
    assign handshake  = m_axis_tvalid && m_axis_tready;
    assign m_axis_tid = tid_q;
    assign sts_packets = sts_q;

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration, next state and zero-latency datapath multiplexing.
    always_comb begin
        state_d        = state_q;
        grant          = 1'b0;
        grant_idx      = rr_ptr;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tdata   = '0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_enable) begin
                    if (src_tvalid[rr_ptr]) begin
                        grant     = 1'b1;
                        grant_idx = rr_ptr;
                    end else if (src_tvalid[other_src(rr_ptr)]) begin
                        grant     = 1'b1;
                        grant_idx = other_src(rr_ptr);
                    end
                end
                if (grant) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                m_axis_tvalid  = tid_q ? s1_axis_tvalid : s0_axis_tvalid;
                m_axis_tdata   = tid_q ? s1_axis_tdata  : s0_axis_tdata;
                s0_axis_tready = (tid_q == src_idx_t'(0)) && m_axis_tready;
                s1_axis_tready = (tid_q == src_idx_t'(1)) && m_axis_tready;
                m_axis_tlast   = terminal;
                if (m_axis_tvalid && m_axis_tready && terminal) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping: packet length, owner, round-robin pointer, packet count.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rr_ptr <= '0;
            tid_q  <= '0;
            len_q  <= '0;
            sts_q  <= '0;
        end else begin
            if (grant) begin
                len_q <= cfg_data;
                tid_q <= grant_idx;
            end
            if (handshake && m_axis_tlast) begin
                rr_ptr <= other_src(tid_q);
                sts_q  <= sts_q + 32'd1;
            end
        end
    end

    pkt_beat_counter #(
        .CNTR_WIDTH (CNTR_WIDTH)
    ) u_beat_cnt (
        .clk      (aclk),
        .reset    (areset),
        .clear    (grant),
        .enable   (handshake),
        .length   (len_q),
        .terminal (terminal)
    );

endmodule

// File: tb/tb_axis_packet_scheduler.sv
// Randomized bench for axis_packet_scheduler with a packet-level reference model.
module tb_axis_packet_scheduler;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] cfg_data;
    logic        cfg_enable;
    logic [31:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic        s0_axis_tvalid, s1_axis_tvalid, s0_axis_tready, s1_axis_tready;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready, m_axis_tid;
    logic [31:0] sts_packets;

    axis_packet_scheduler #(
        .AXIS_TDATA_WIDTH (32),
        .CNTR_WIDTH       (32)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .cfg_data       (cfg_data),
        .cfg_enable     (cfg_enable),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tready (s0_axis_tready),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tready (s1_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tid     (m_axis_tid),
        .sts_packets    (sts_packets)
    );

    always #5 aclk = ~aclk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: who owns the output, how many beats are left, whose turn next.
    int          owner     = -1;
    longint      remaining = 0;
    int          pref      = 0;
    int          last_tid  = 0;
    int          beats     = 0;
    int unsigned pkts      = 0;
    int unsigned seq [2]   = '{0, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_sources();
        s0_axis_tdata = {1'b0, seq[0][30:0]};
        s1_axis_tdata = {1'b1, seq[1][30:0]};
    endtask

    task automatic compare_and_update();
        logic        sv [2];
        logic [31:0] sd [2];
        logic        hs;
        sv[0] = s0_axis_tvalid; sv[1] = s1_axis_tvalid;
        sd[0] = s0_axis_tdata;  sd[1] = s1_axis_tdata;
        if (owner < 0) begin
            check("idle_tvalid", m_axis_tvalid, 0);
            check("idle_tlast", m_axis_tlast, 0);
            check("idle_s0_tready", s0_axis_tready, 0);
            check("idle_s1_tready", s1_axis_tready, 0);
            check("tdata_known", $isunknown(m_axis_tdata), 0);
        end else begin
            check("tvalid", m_axis_tvalid, sv[owner]);
            if (sv[owner]) check("tdata", m_axis_tdata, sd[owner]);
            check("s0_tready", s0_axis_tready, (owner == 0) ? m_axis_tready : 1'b0);
            check("s1_tready", s1_axis_tready, (owner == 1) ? m_axis_tready : 1'b0);
            check("tlast", m_axis_tlast, (remaining == 1));
        end
        check("tid", m_axis_tid, last_tid);
        check("sts_packets", sts_packets, pkts);

        hs = (owner >= 0) && sv[owner] && m_axis_tready;
        if (hs) seq[owner]++;
        if (areset) begin
            owner = -1; pref = 0; pkts = 0; last_tid = 0; beats = 0;
        end else if (owner < 0) begin
            if (cfg_enable) begin
                if (sv[pref]) owner = pref;
                else if (sv[1-pref]) owner = 1 - pref;
            end
            if (owner >= 0) begin
                remaining = longint'(cfg_data) + 1;
                last_tid  = owner;
                beats     = 0;
            end
        end else if (hs) begin
            remaining--;
            beats++;
            if (remaining == 0) begin
                pref  = 1 - owner;
                owner = -1;
                pkts++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge aclk);
        compare_and_update();
        @(posedge aclk);
        #1;
        drive_sources();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic found;
        areset = 1'b1; cfg_data = 32'd3; cfg_enable = 1'b1;
        s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        drive_sources();
        repeat (2) @(posedge aclk);
        #1;
        cycle();                      // reset state check with areset still high
        areset = 1'b0;

        // Only s0 valid, 4-beat packets with a one-cycle bubble between them.
        cfg_data = 32'd3; s0_axis_tvalid = 1'b1;
        run(40);

        // Both valid, 2-beat packets alternating between sources.
        cfg_data = 32'd1; s1_axis_tvalid = 1'b1;
        run(40);

        // Back-pressure toggling every cycle.
        cfg_data = 32'd4;
        for (int i = 0; i < 60; i++) begin
            m_axis_tready = i[0];
            cycle();
        end
        m_axis_tready = 1'b1;

        // Length changed mid-packet must only affect the next grant.
        s1_axis_tvalid = 1'b0; cfg_data = 32'd9;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (owner >= 0 && remaining == 10 - 3) found = 1'b1;
            else cycle();
        end
        check("wait_len_change", found, 1);
        cfg_data = 32'd2;
        run(40);

        // Enable dropped mid-packet: packet finishes, then no grants.
        cfg_data = 32'd5; s1_axis_tvalid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (owner >= 0 && remaining == 6 - 2) found = 1'b1;
            else cycle();
        end
        check("wait_enable_drop", found, 1);
        cfg_enable = 1'b0;
        run(20);
        cfg_enable = 1'b1;

        // Reset in the middle of a long packet; next grant goes to s0.
        cfg_data = 32'd99;
        found = 1'b0;
        for (int i = 0; i < 250 && !found; i++) begin
            if (owner >= 0 && remaining == 100 && beats == 0) begin
                run(5);
                found = 1'b1;
            end else cycle();
        end
        check("wait_long_packet", found, 1);
        areset = 1'b1;
        cycle();
        areset = 1'b0;
        run(10);

        // Random traffic, back-pressure, lengths, enable and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            s0_axis_tvalid = $urandom_range(0, 3) != 0;
            s1_axis_tvalid = $urandom_range(0, 2) != 0;
            m_axis_tready  = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 9) == 0) cfg_data = $urandom_range(0, 5);
            cfg_enable = $urandom_range(0, 19) != 0;
            areset     = $urandom_range(0, 199) == 0;
            cycle();
        end
        areset = 1'b0;
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
